mult_lp: RTL and testbench
==========================

Name: mult_lp

Overview:
- Unsigned WIDTH x WIDTH low-power multiplier (default 8x8 -> 16-bit product).
- Two-stage pipeline: operand registers, then a carry-save partial-product array feeding a registered product.
- Operand isolation: registers load only on valid input, so the array does not toggle while idle.
- Used as a datapath arithmetic leaf; upstream drives operands with in_valid, downstream consumes product on out_valid.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; captured on the rising edge.
- multiplicand  input  WIDTH  unsigned operand A.
- multiplier  input  WIDTH  unsigned operand B.
- product  output  2*WIDTH  registered unsigned A*B.
- out_valid  output  1  product updated this cycle (one-cycle pulse per accepted operand pair).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Operand regs, stage-1 valid, product and out_valid all clear to 0 immediately.
  - Values stay 0 while rst_n is low.
  - Release is synchronous to the next rising edge.
- Stage 1, rising edge with in_valid=1:
  - opA <= multiplicand, opB <= multiplier, v1 <= 1.
  - A zero flag is registered if either operand is 0.
- Stage 1, in_valid=0:
  - opA and opB hold their values (no toggling); v1 <= 0.
- Stage 2 array:
  - WIDTH partial products pp[i] = opA & {WIDTH{opB[i]}}.
  - Reduced with a carry-save full/half-adder array, then a final ripple carry-propagate adder.
  - Implement structurally from adder cells; no behavioural '*' operator.
- Stage 2 register, rising edge with v1=1:
  - product <= array result, or 0 when the zero flag is set (bypass).
  - out_valid <= 1.
- Stage 2 register, v1=0:
  - product holds its last value; out_valid <= 0.
- Latency: in_valid sampled at edge k -> product and out_valid valid after edge k+1, i.e. 2 cycles from input presentation to output.
- Throughput: one operand pair per cycle; back-to-back valid inputs give back-to-back out_valid.
- No backpressure: out_valid is a pulse, and the consumer must capture the product that cycle or rely on its hold.
- Arithmetic:
  - Unsigned, exact, no overflow; max 255*255 = 65025 = 0xFE01 at WIDTH=8.
- Boundaries:
  - Either operand 0 -> product 0 via the zero flag.
  - Operand 1 -> product equals the other operand.
  - All-ones operands -> 2^(2W) - 2^(W+1) + 1.
- Reset mid-operation: in-flight data is discarded; no out_valid is produced for operands accepted before reset.
- Inputs are don't-care when in_valid=0; X on them must not propagate to product.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> product=0 and out_valid=0 immediately, without a clock edge. Release, then idle 3 cycles -> outputs remain 0.
- Directed vectors, one per cycle with in_valid=1:
  - (15,10) -> 150
  - (255,255) -> 65025
  - (0,100) -> 0
  - (123,45) -> 5535
  - (50,50) -> 2500
  - Each appears 2 cycles after presentation with out_valid=1 for exactly one cycle; back-to-back, no bubbles.
- Hold/isolation: after (123,45), drop in_valid and toggle the operand inputs randomly for 5 cycles -> product stays 5535, out_valid=0, and opA/opB do not change.
- Zero bypass: (0,255) and (255,0) -> product 0. Then (1,200) -> 200 and (200,1) -> 200.
- Reset mid-pipeline: present (50,50) and assert rst_n low before its product emerges -> after release, no out_valid pulse and product=0. Next accepted (15,10) yields 150.
- Random: 1000 random unsigned pairs with random in_valid gaps -> every out_valid product matches a scoreboard A*B in order.

Source files
------------

// File: rtl/mult_lp.sv
// Unsigned WIDTH x WIDTH low-power multiplier: operand-isolated input registers,
// carry-save partial-product array with ripple final adder, registered product.

module mult_lp_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module mult_lp #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid
);

  logic [WIDTH-1:0]   opa_p1, opb_p1;
  logic               vld_p1, zero_p1;
  logic [2*WIDTH-1:0] arr_p1;
  logic [2*WIDTH-1:0] prod_p2;
  logic               vld_p2;

  // Stage 1: operand registers, loaded only on accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p1  <= '0;
      opb_p1  <= '0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        opa_p1  <= multiplicand;
        opb_p1  <= multiplier;
        zero_p1 <= (multiplicand == '0) || (multiplier == '0);
      end
    end
  end

  logic [WIDTH-1:0] pp    [WIDTH];
  logic [WIDTH-1:0] s_row [WIDTH];
  logic [WIDTH-1:0] c_row [WIDTH];
  logic [WIDTH-1:0] rc;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i] = opa_p1 & {WIDTH{opb_p1[i]}};
  end

  assign s_row[0] = pp[0];
  assign c_row[0] = '0;

  // Row i bit j carries weight 2^(i+j); the shifted previous sum and the
  // previous carries line up on the same weight.
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      if (j == WIDTH - 1) begin : g_top
        mult_lp_fa u_fa (
          .a  (pp[i][j]),
          .b  (1'b0),
          .ci (c_row[i-1][j]),
          .s  (s_row[i][j]),
          .co (c_row[i][j])
        );
      end else begin : g_mid
        mult_lp_fa u_fa (
          .a  (pp[i][j]),
          .b  (s_row[i-1][j+1]),
          .ci (c_row[i-1][j]),
          .s  (s_row[i][j]),
          .co (c_row[i][j])
        );
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_low
    assign arr_p1[i] = s_row[i][0];
  end

  // Final carry-propagate adder over the last sum/carry rows
  assign rc[0] = 1'b0;
  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_cpa
    mult_lp_fa u_fa (
      .a  (s_row[WIDTH-1][k+1]),
      .b  (c_row[WIDTH-1][k]),
      .ci (rc[k]),
      .s  (arr_p1[WIDTH+k]),
      .co (rc[k+1])
    );
  end
  // Exact product fits in 2*WIDTH bits, so the top carry-out is always zero.
  assign arr_p1[2*WIDTH-1] = c_row[WIDTH-1][WIDTH-1] ^ rc[WIDTH-1];

  // Stage 2: product register with zero bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        prod_p2 <= zero_p1 ? '0 : arr_p1;
      end
    end
  end

  assign product   = prod_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_mult_lp.sv
// Scoreboard bench for mult_lp: directed vectors, hold/isolation, zero bypass,
// asynchronous reset mid-pipeline and random traffic.

module tb_mult_lp;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  mc, mr;
  logic [15:0] product;
  logic        out_valid;

  int checks = 0;
  int errs   = 0;
  int pulses = 0;
  logic [15:0] exp_q [$];

  mult_lp #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .multiplicand (mc),
    .multiplier   (mr),
    .product      (product),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pop one expected product per out_valid pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out_valid: got product %0d expected no pulse", product);
        end else begin
          chk("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e, input bit push);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    mc = a;
    mr = b;
    if (push) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mc = 8'($urandom);
      mr = 8'($urandom);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    mc = '0;
    mr = '0;
    #1;
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_product", {16'd0, product}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Directed back-to-back vectors; pulse count shows no bubbles or extras
    p0 = pulses;
    send(8'd15,  8'd10,  16'd150,   1'b1);
    send(8'd255, 8'd255, 16'd65025, 1'b1);
    send(8'd0,   8'd100, 16'd0,     1'b1);
    send(8'd123, 8'd45,  16'd5535,  1'b1);
    send(8'd50,  8'd50,  16'd2500,  1'b1);
    idle(4);
    chk("directed_pulses", pulses - p0, 32'd5);

    // Hold / operand isolation
    send(8'd123, 8'd45, 16'd5535, 1'b1);
    idle(2);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mc = 8'($urandom);
      mr = 8'($urandom);
      @(negedge clk);
      chk("hold_product", {16'd0, product}, 32'd5535);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_opa", {24'd0, dut.opa_p1}, 32'd123);
      chk("hold_opb", {24'd0, dut.opb_p1}, 32'd45);
    end

    // Zero bypass and identity
    send(8'd0,   8'd255, 16'd0,   1'b1);
    send(8'd255, 8'd0,   16'd0,   1'b1);
    send(8'd1,   8'd200, 16'd200, 1'b1);
    send(8'd200, 8'd1,   16'd200, 1'b1);
    idle(3);
    chk("bypass_last_product", {16'd0, product}, 32'd200);

    // Reset while (50,50) is in flight
    send(8'd50, 8'd50, 16'd2500, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_product", {16'd0, product}, 32'd0);
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    p0 = pulses;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_product", {16'd0, product}, 32'd0);
    end
    chk("post_reset_pulses", pulses - p0, 32'd0);
    send(8'd15, 8'd10, 16'd150, 1'b1);
    idle(3);
    chk("post_reset_first", {16'd0, product}, 32'd150);

    // Random traffic with gaps
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ra, rb, 16'(ra) * 16'(rb), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
